// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types for the program sequencer.
//   seq_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   seq_step_t  : what a RUN edge does, listed from highest to lowest priority
// No ports; imported by prog_sequencer and pc_next.
// ---------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // Step codes for one RUN edge, in priority order
   typedef enum logic [2:0] {
      STEP_STALL = 3'd0,   // hold PC, only the cycle counter moves
      STEP_WDOG  = 3'd1,   // watchdog expired
      STEP_HALT  = 3'd2,   // halt instruction or implicit end PC
      STEP_ABS   = 3'd3,   // absolute jump
      STEP_REL   = 3'd4,   // signed relative jump
      STEP_INC   = 3'd5    // sequential fetch
   } seq_step_t;

endpackage

// File: rtl/prog_sequencer_pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection for a RUN edge that actually advances.
//   prog_ctr   in  D  current PC
//   target     in  D  jump target / two's complement offset
//   absjump_en in  1  absolute jump (wins over relative)
//   reljump_en in  1  relative jump
//   next_pc    out D  PC to load
//   step       out 3  seq_step_t code of the chosen move (ABS/REL/INC)
// ---------------------------------------------------------------------------
module pc_next
   import seq_pkg::*;
#(
   parameter int D = 12
) (
   input  logic [D-1:0] prog_ctr,
   input  logic [D-1:0] target,
   input  logic         absjump_en,
   input  logic         reljump_en,
   output logic [D-1:0] next_pc,
   output logic [2:0]   step
);

   // Select jump/increment; D-bit addition gives the silent modulo-2^D wrap,
   // and a two's complement offset needs no sign extension at equal width.
   always_comb begin
      next_pc = prog_ctr + D'(1);
      step    = STEP_INC;
      if (absjump_en) begin
         next_pc = target;
         step    = STEP_ABS;
      end else if (reljump_en) begin
         next_pc = prog_ctr + target;
         step    = STEP_REL;
      end else begin
         next_pc = prog_ctr + D'(1);
         step    = STEP_INC;
      end
   end

endmodule

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
// Fetch/run controller for the single-cycle core. A host raises req (level,
// four-phase); the sequencer loads start_pc, steps the PC each cycle
// (stall / watchdog / halt / abs jump / rel jump / increment, in that
// priority) and parks in DONE until req is dropped.
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset
//   req        in   1   run request
//   start_pc   in   D   first PC, sampled in IDLE
//   stall      in   1   freeze PC this cycle
//   halt       in   1   decoded halt at current PC
//   absjump_en in   1   PC <= target
//   reljump_en in   1   PC <= PC + signed target
//   target     in   D   jump target / offset
//   prog_ctr   out  D   current PC
//   busy       out  1   in RUN
//   done       out  1   in DONE
//   timeout    out  1   last run ended by watchdog
//   cycles     out  CW  saturating RUN-cycle count
// Outputs come only from registers (state decode included).
// ---------------------------------------------------------------------------
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int D       = 12,
   parameter int DONE_PC = 128,
   parameter int CW      = 16,
   parameter int MAX_CYC = 4000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [D-1:0]  start_pc,
   input  logic          stall,
   input  logic          halt,
   input  logic          absjump_en,
   input  logic          reljump_en,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycles
);

   localparam logic [D-1:0]  DONE_PC_V = D'(DONE_PC);
   localparam logic [CW-1:0] WD_LAST   = CW'(MAX_CYC - 1);
   localparam logic [CW-1:0] CYC_SAT   = {CW{1'b1}};
   localparam bit            WD_EN     = (MAX_CYC != 0);

   seq_state_t     state_r;
   logic [D-1:0]   prog_ctr_r;
   logic [CW-1:0]  cycles_r;
   logic           timeout_r;

   logic [D-1:0]   next_pc_s;
   logic [2:0]     pc_step_s;
   logic [2:0]     step_s;
   logic [CW-1:0]  cycles_inc_s;

   pc_next #(
      .D (D)
   ) u_pc_next (
      .prog_ctr   (prog_ctr_r),
      .target     (target),
      .absjump_en (absjump_en),
      .reljump_en (reljump_en),
      .next_pc    (next_pc_s),
      .step       (pc_step_s)
   );

   // Resolve what this RUN edge does. Stall outranks the watchdog, so the
   // timeout decision is deferred while the memory op is in flight.
   always_comb begin
      step_s = pc_step_s;
      if (stall) begin
         step_s = STEP_STALL;
      end else if (WD_EN && (cycles_r == WD_LAST)) begin
         step_s = STEP_WDOG;
      end else if (halt || (prog_ctr_r == DONE_PC_V)) begin
         step_s = STEP_HALT;
      end else begin
         step_s = pc_step_s;
      end
   end

   // Saturating increment of the run-cycle counter
   always_comb begin
      cycles_inc_s = cycles_r;
      if (cycles_r == CYC_SAT) begin
         cycles_inc_s = cycles_r;
      end else begin
         cycles_inc_s = cycles_r + CW'(1);
      end
   end

   // Sequencer FSM with registered PC, counter and timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         prog_ctr_r <= {D{1'b0}};
         cycles_r   <= {CW{1'b0}};
         timeout_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req) begin
                  state_r    <= RUN;
                  prog_ctr_r <= start_pc;
                  cycles_r   <= {CW{1'b0}};
                  timeout_r  <= 1'b0;
               end
            end
            RUN: begin
               // every RUN edge counts, including the one that leaves RUN
               cycles_r <= cycles_inc_s;
               case (step_s)
                  STEP_STALL: begin
                     prog_ctr_r <= prog_ctr_r;
                  end
                  STEP_WDOG: begin
                     state_r   <= DONE;
                     timeout_r <= 1'b1;
                  end
                  STEP_HALT: begin
                     state_r <= DONE;
                  end
                  STEP_ABS, STEP_REL, STEP_INC: begin
                     prog_ctr_r <= next_pc_s;
                  end
                  default: begin
                     prog_ctr_r <= prog_ctr_r;
                  end
               endcase
            end
            DONE: begin
               // no auto-restart: the host must drop req first
               if (!req) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign prog_ctr = prog_ctr_r;
   assign busy     = (state_r == RUN);
   assign done     = (state_r == DONE);
   assign timeout  = timeout_r;
   assign cycles   = cycles_r;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
// Two instances share one stimulus: dut_a with default parameters and dut_b
// with a 4-bit counter and a 10-cycle watchdog. A rule-level model per
// instance is compared on every falling edge; directed scenarios add literal
// expectations, then a randomized phase exercises the rules.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [11:0] start_pc;
   logic        stall;
   logic        halt;
   logic        absjump_en;
   logic        reljump_en;
   logic [11:0] target;

   logic [11:0] a_prog_ctr, b_prog_ctr;
   logic        a_busy, a_done, a_timeout;
   logic        b_busy, b_done, b_timeout;
   logic [15:0] a_cycles;
   logic [3:0]  b_cycles;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   prog_sequencer #(.D(12), .DONE_PC(128), .CW(16), .MAX_CYC(4000)) dut_a (
      .clk(clk), .reset(reset), .req(req), .start_pc(start_pc), .stall(stall),
      .halt(halt), .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
      .prog_ctr(a_prog_ctr), .busy(a_busy), .done(a_done), .timeout(a_timeout),
      .cycles(a_cycles)
   );

   prog_sequencer #(.D(12), .DONE_PC(128), .CW(4), .MAX_CYC(10)) dut_b (
      .clk(clk), .reset(reset), .req(req), .start_pc(start_pc), .stall(stall),
      .halt(halt), .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
      .prog_ctr(b_prog_ctr), .busy(b_busy), .done(b_done), .timeout(b_timeout),
      .cycles(b_cycles)
   );

   // ---------------- behavioural model ----------------
   // mode: 0 = idle, 1 = running, 2 = finished
   typedef struct {
      int mode;
      int pc;
      int cyc;
      bit to;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_clear();
      mdl_t m;
      m.mode = 0; m.pc = 0; m.cyc = 0; m.to = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int max_cyc, int cyc_cap);
      mdl_t n = m;
      if (m.mode == 0) begin
         if (req) begin
            n.mode = 1; n.pc = int'(start_pc); n.cyc = 0; n.to = 1'b0;
         end
      end else if (m.mode == 1) begin
         n.cyc = (m.cyc < cyc_cap) ? m.cyc + 1 : cyc_cap;
         if (stall) begin
            n.pc = m.pc;
         end else if (max_cyc != 0 && m.cyc == max_cyc - 1) begin
            n.mode = 2; n.to = 1'b1;
         end else if (halt || m.pc == 128) begin
            n.mode = 2;
         end else if (absjump_en) begin
            n.pc = int'(target);
         end else if (reljump_en) begin
            n.pc = (m.pc + int'($signed(target))) & 4095;
         end else begin
            n.pc = (m.pc + 1) % 4096;
         end
      end else begin
         if (!req) n.mode = 0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma <= mdl_clear();
         mb <= mdl_clear();
      end else begin
         ma <= mdl_step(ma, 4000, 65535);
         mb <= mdl_step(mb, 10, 15);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("a_pc",      32'(a_prog_ctr), 32'(ma.pc));
         check("a_busy",    32'(a_busy),     32'(ma.mode == 1));
         check("a_done",    32'(a_done),     32'(ma.mode == 2));
         check("a_timeout", 32'(a_timeout),  32'(ma.to));
         check("a_cycles",  32'(a_cycles),   32'(ma.cyc));
         check("b_pc",      32'(b_prog_ctr), 32'(mb.pc));
         check("b_busy",    32'(b_busy),     32'(mb.mode == 1));
         check("b_done",    32'(b_done),     32'(mb.mode == 2));
         check("b_timeout", 32'(b_timeout),  32'(mb.to));
         check("b_cycles",  32'(b_cycles),   32'(mb.cyc));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      stall = 1'b0; halt = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0; target = 12'h000;
   endtask

   // Wait (bounded) for done on instance a (sel=0) or b (sel=1)
   task automatic wait_done(input bit sel, input int budget, output int edges);
      edges = 0;
      while (((sel ? b_done : a_done) !== 1'b1) && edges < budget) begin
         tick();
         edges++;
      end
      check(sel ? "b_done_wait" : "a_done_wait", 32'(sel ? b_done : a_done), 32'd1);
   endtask

   initial begin
      int edges;
      int off;
      reset = 1'b1; req = 1'b0; start_pc = 12'h000;
      clear_in();
      #1 reset = 1'b0;
      #1;
      check("rst_pc",      32'(a_prog_ctr), 32'h0);
      check("rst_busy",    32'(a_busy),     32'h0);
      check("rst_done",    32'(a_done),     32'h0);
      check("rst_cycles",  32'(a_cycles),   32'h0);
      check("rst_timeout", 32'(a_timeout),  32'h0);
      chk_en = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();

      // T2: sequential run to the implicit end PC
      start_pc = 12'h010; req = 1'b1;
      tick();
      check("t2_busy", 32'(a_busy), 32'h1);
      check("t2_pc0",  32'(a_prog_ctr), 32'h010);
      wait_done(1'b0, 200, edges);
      check("t2_pc_end",  32'(a_prog_ctr), 32'h080);
      check("t2_cycles",  32'(a_cycles),   32'h71);
      check("t2_timeout", 32'(a_timeout),  32'h0);
      req = 1'b0;
      tick();
      check("t2_done_drop", 32'(a_done), 32'h0);

      // T3: relative jumps backwards and across the wrap
      start_pc = 12'h005; req = 1'b1;
      tick();
      reljump_en = 1'b1; target = 12'hFFD;
      tick();
      check("t3_rel_neg", 32'(a_prog_ctr), 32'h002);
      reljump_en = 1'b0; absjump_en = 1'b1; target = 12'hFFE;
      tick();
      check("t3_abs", 32'(a_prog_ctr), 32'hFFE);
      absjump_en = 1'b0; reljump_en = 1'b1; target = 12'h004;
      tick();
      check("t3_rel_wrap", 32'(a_prog_ctr), 32'h002);
      clear_in(); halt = 1'b1;
      tick();
      check("t3_halt_done", 32'(a_done), 32'h1);
      check("t3_halt_pc",   32'(a_prog_ctr), 32'h002);
      clear_in(); req = 1'b0;
      tick();

      // T4: abs beats rel; halt beats abs
      start_pc = 12'h100; req = 1'b1;
      tick();
      absjump_en = 1'b1; reljump_en = 1'b1; target = 12'h040;
      tick();
      check("t4_abs_wins", 32'(a_prog_ctr), 32'h040);
      reljump_en = 1'b0; halt = 1'b1; target = 12'h300;
      tick();
      check("t4_halt_done", 32'(a_done), 32'h1);
      check("t4_halt_pc",   32'(a_prog_ctr), 32'h040);
      clear_in(); req = 1'b0;
      tick();

      // T5: stall freezes PC and hides halt
      start_pc = 12'h030; req = 1'b1;
      tick();
      stall = 1'b1; halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_stall_pc",   32'(a_prog_ctr), 32'h030);
         check("t5_stall_busy", 32'(a_busy),     32'h1);
      end
      check("t5_cycles", 32'(a_cycles), 32'h3);
      stall = 1'b0;
      tick();
      check("t5_halt_done", 32'(a_done),     32'h1);
      check("t5_halt_pc",   32'(a_prog_ctr), 32'h030);
      clear_in(); req = 1'b0;
      tick();

      // T1: reset mid-run aborts without a done pulse
      start_pc = 12'h020; req = 1'b1;
      tick();
      check("t1_pc_run", 32'(a_prog_ctr), 32'h020);
      #3 reset = 1'b0;
      #1;
      check("t1_pc",      32'(a_prog_ctr), 32'h0);
      check("t1_busy",    32'(a_busy),     32'h0);
      check("t1_done",    32'(a_done),     32'h0);
      check("t1_cycles",  32'(a_cycles),   32'h0);
      check("t1_b_pc",    32'(b_prog_ctr), 32'h0);
      req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("t1_idle_busy", 32'(a_busy), 32'h0);
      check("t1_idle_done", 32'(a_done), 32'h0);

      // T6: watchdog on dut_b via a tight self loop
      start_pc = 12'h100; req = 1'b1; absjump_en = 1'b1; target = 12'h100;
      tick();
      wait_done(1'b1, 40, edges);
      check("t6_edges",   32'(edges),      32'd10);
      check("t6_timeout", 32'(b_timeout),  32'h1);
      check("t6_cycles",  32'(b_cycles),   32'd10);
      check("t6_pc",      32'(b_prog_ctr), 32'h100);
      repeat (3) tick();
      check("t6_hold_done", 32'(b_done), 32'h1);
      req = 1'b0;
      tick();
      check("t6_idle", 32'(b_done), 32'h0);
      req = 1'b1;
      tick();
      check("t6_rerun_busy",    32'(b_busy),    32'h1);
      check("t6_rerun_timeout", 32'(b_timeout), 32'h0);
      clear_in(); halt = 1'b1;
      tick();
      clear_in(); req = 1'b0;
      tick();

      // Randomized phase, checked by the per-cycle model compare
      for (int i = 0; i < 3000; i++) begin
         reset = 1'b1;
         if ($urandom_range(0, 999) < 3) reset = 1'b0;
         if ($urandom_range(0, 99) < 10) req = ~req;
         case ($urandom_range(0, 3))
            0:       start_pc = 12'h070 + 12'($urandom_range(0, 31));
            1:       start_pc = 12'hFF0 + 12'($urandom_range(0, 15));
            default: start_pc = 12'($urandom);
         endcase
         stall      = ($urandom_range(0, 99) < 20);
         halt       = ($urandom_range(0, 99) < 3);
         absjump_en = ($urandom_range(0, 99) < 8);
         reljump_en = ($urandom_range(0, 99) < 15);
         if ($urandom_range(0, 1) == 0) begin
            off    = int'($urandom_range(0, 16)) - 8;
            target = 12'(off);
         end else begin
            target = 12'($urandom);
         end
         tick();
      end
      reset = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
